// File: rtl/adder_collector_pkg.sv
// Shared register map, CTRL bit positions and counter helpers for the adder result collector.
package adder_collector_pkg;

   localparam int CNT_W = 8;

   localparam logic [2:0] ADDR_CTRL  = 3'd0;
   localparam logic [2:0] ADDR_LEVEL = 3'd1;
   localparam logic [2:0] ADDR_CARRY = 3'd2;
   localparam logic [2:0] ADDR_DROP  = 3'd3;
   localparam logic [2:0] ADDR_TOTAL = 3'd4;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered read data, a one-cycle read strobe and a flush.
module result_fifo #(
   parameter int DW    = 9,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              dout,
   output logic                       dout_vld,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          vld_q, vld_d;
   logic          do_push, do_pop;

   assign empty   = (lvl_q == '0);
   assign full    = (lvl_q == LW'(DEPTH));
   // A pop frees the slot, so a push into a full FIFO still lands when it pops too.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      lvl_d  = lvl_q;
      dout_d = dout_q;
      vld_d  = 1'b0;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         lvl_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop) begin
            rd_d   = rd_q + 1'b1;
            dout_d = mem[rd_q];
            vld_d  = 1'b1;
         end
         if (do_push && !do_pop)      lvl_d = lvl_q + LW'(1);
         else if (do_pop && !do_push) lvl_d = lvl_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         lvl_q  <= '0;
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         lvl_q  <= lvl_d;
         dout_q <= dout_d;
         vld_q  <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && do_push) mem[wr_q] <= din;
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign level    = lvl_q;

endmodule

// File: rtl/adder_result_collector.sv
// Captures adder sum/carry into a FIFO, keeps capture statistics and exposes them on the DES bus.
module adder_result_collector
   import adder_collector_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] Sum_result,
   input  logic             Sum_carry,
   input  logic             Data_ready,
   input  logic             Pop_req,
   output logic [WIDTH:0]   Pop_data,
   output logic             Pop_valid,
   output logic             Fifo_empty,
   output logic             Fifo_full,
   input  logic [7:0]       Des_value,
   input  logic [2:0]       Des_address,
   input  logic             Des_req_valid,
   input  logic             Des_wr_rd,
   output logic [7:0]       Des_rd_value
);
   logic                    en_q, en_d;
   logic [CNT_W-1:0]        carry_q, carry_d, drop_q, drop_d, total_q, total_d;
   logic [7:0]              rd_q, rd_d;
   logic [$clog2(DEPTH):0]  level;
   logic                    ctrl_wr, clr, push_req, push_ok, pop_ok, drop;

   assign ctrl_wr  = Des_req_valid && Des_wr_rd && (Des_address == ADDR_CTRL);
   assign clr      = ctrl_wr && Des_value[CTRL_CLR_BIT];
   assign push_req = Data_ready && en_q;
   assign pop_ok   = Pop_req && !Fifo_empty;
   assign push_ok  = push_req && (!Fifo_full || pop_ok);
   assign drop     = push_req && !push_ok;

   result_fifo #(.DW(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_req),
      .pop      (Pop_req),
      .flush    (clr),
      .din      ({Sum_carry, Sum_result}),
      .dout     (Pop_data),
      .dout_vld (Pop_valid),
      .level    (level),
      .full     (Fifo_full),
      .empty    (Fifo_empty)
   );

   always_comb begin
      en_d    = en_q;
      carry_d = carry_q;
      drop_d  = drop_q;
      total_d = total_q;
      rd_d    = rd_q;
      if (ctrl_wr) en_d = Des_value[CTRL_EN_BIT];
      if (clr) begin
         carry_d = '0;
         drop_d  = '0;
         total_d = '0;
      end else begin
         if (push_ok)              total_d = total_q + 1'b1;
         if (push_ok && Sum_carry) carry_d = sat_inc(carry_q);
         if (drop)                 drop_d  = sat_inc(drop_q);
      end
      // Reads sample the registered state, so a same-edge write or count shows the old value.
      if (Des_req_valid && !Des_wr_rd) begin
         case (Des_address)
            ADDR_CTRL:  rd_d = {7'b0, en_q};
            ADDR_LEVEL: rd_d = 8'(level);
            ADDR_CARRY: rd_d = carry_q;
            ADDR_DROP:  rd_d = drop_q;
            ADDR_TOTAL: rd_d = total_q;
            default:    rd_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q    <= 1'b1;
         carry_q <= '0;
         drop_q  <= '0;
         total_q <= '0;
         rd_q    <= '0;
      end else begin
         en_q    <= en_d;
         carry_q <= carry_d;
         drop_q  <= drop_d;
         total_q <= total_d;
         rd_q    <= rd_d;
      end
   end

   assign Des_rd_value = rd_q;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector with DEPTH=4 and hand-computed expectations.
module tb_adder_result_collector;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] Sum_result;
   logic       Sum_carry, Data_ready, Pop_req;
   logic [8:0] Pop_data;
   logic       Pop_valid, Fifo_empty, Fifo_full;
   logic [7:0] Des_value;
   logic [2:0] Des_address;
   logic       Des_req_valid, Des_wr_rd;
   logic [7:0] Des_rd_value;

   int n_assert = 0;
   int n_fail   = 0;

   adder_result_collector #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .Sum_result(Sum_result), .Sum_carry(Sum_carry), .Data_ready(Data_ready),
      .Pop_req(Pop_req), .Pop_data(Pop_data), .Pop_valid(Pop_valid),
      .Fifo_empty(Fifo_empty), .Fifo_full(Fifo_full),
      .Des_value(Des_value), .Des_address(Des_address), .Des_req_valid(Des_req_valid),
      .Des_wr_rd(Des_wr_rd), .Des_rd_value(Des_rd_value)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] s, input logic c);
      Sum_result = s; Sum_carry = c; Data_ready = 1'b1;
      tick();
      Data_ready = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [8:0] exp);
      Pop_req = 1'b1;
      tick();
      Pop_req = 1'b0;
      chk({tag, "_valid"}, 32'(Pop_valid), 32'd1);
      chk({tag, "_data"}, 32'(Pop_data), 32'(exp));
   endtask

   task automatic des_wr(input logic [2:0] a, input logic [7:0] v);
      Des_req_valid = 1'b1; Des_wr_rd = 1'b1; Des_address = a; Des_value = v;
      tick();
      Des_req_valid = 1'b0; Des_wr_rd = 1'b0;
   endtask

   task automatic des_rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
      Des_req_valid = 1'b1; Des_wr_rd = 1'b0; Des_address = a;
      tick();
      Des_req_valid = 1'b0;
      chk(tag, 32'(Des_rd_value), 32'(exp));
   endtask

   initial begin
      reset = 1'b1; Sum_result = '0; Sum_carry = 1'b0; Data_ready = 1'b0; Pop_req = 1'b0;
      Des_value = '0; Des_address = '0; Des_req_valid = 1'b0; Des_wr_rd = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_pop_data", 32'(Pop_data), 32'h0);
      chk("rst_pop_valid", 32'(Pop_valid), 32'h0);
      chk("rst_empty", 32'(Fifo_empty), 32'h1);
      chk("rst_full", 32'(Fifo_full), 32'h0);
      chk("rst_rd_value", 32'(Des_rd_value), 32'h0);
      des_rd_chk("rst_ctrl", 3'd0, 8'h01);
      des_rd_chk("unmapped_rd", 3'd5, 8'h00);

      // Two pushes, then two pops.
      push(8'h0F, 1'b0);
      push(8'hFF, 1'b1);
      des_rd_chk("lvl_two", 3'd1, 8'd2);
      pop_chk("pop1", 9'h00F);
      pop_chk("pop2", 9'h1FF);
      des_rd_chk("carry_cnt1", 3'd2, 8'd1);
      des_rd_chk("total_cnt2", 3'd4, 8'd2);
      des_rd_chk("lvl_zero", 3'd1, 8'd0);
      chk("empty_after", 32'(Fifo_empty), 32'h1);

      // Overflow: six pushes into four slots.
      des_wr(3'd0, 8'h03);
      for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b0);
      chk("full_flag", 32'(Fifo_full), 32'h1);
      des_rd_chk("lvl_full", 3'd1, 8'd4);
      des_rd_chk("drop_cnt2", 3'd3, 8'd2);

      // Push and pop together while full.
      Sum_result = 8'h20; Sum_carry = 1'b0; Data_ready = 1'b1; Pop_req = 1'b1;
      tick();
      Data_ready = 1'b0; Pop_req = 1'b0;
      chk("fullpp_valid", 32'(Pop_valid), 32'h1);
      chk("fullpp_data", 32'(Pop_data), 32'h010);
      chk("fullpp_full", 32'(Fifo_full), 32'h1);
      des_rd_chk("fullpp_lvl", 3'd1, 8'd4);
      des_rd_chk("fullpp_drop", 3'd3, 8'd2);
      pop_chk("ovf_pop1", 9'h011);
      pop_chk("ovf_pop2", 9'h012);
      pop_chk("ovf_pop3", 9'h013);
      pop_chk("ovf_pop4", 9'h020);

      // Pop on empty is ignored and holds Pop_data.
      Pop_req = 1'b1;
      tick();
      Pop_req = 1'b0;
      chk("empty_pop_valid", 32'(Pop_valid), 32'h0);
      chk("empty_pop_data", 32'(Pop_data), 32'h020);

      // Capture disabled.
      des_wr(3'd0, 8'h00);
      push(8'h33, 1'b1);
      des_rd_chk("dis_total", 3'd4, 8'd5);
      chk("dis_empty", 32'(Fifo_empty), 32'h1);
      des_rd_chk("dis_ctrl", 3'd0, 8'h00);
      des_wr(3'd5, 8'hFF);
      des_wr(3'd2, 8'h77);
      des_rd_chk("ro_carry", 3'd2, 8'd0);
      des_wr(3'd0, 8'h03);

      // 300 carry pushes streamed against a held Pop_req.
      Pop_req = 1'b1;
      Sum_carry = 1'b1;
      Data_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         Sum_result = 8'(i);
         tick();
      end
      Data_ready = 1'b0;
      tick();
      Pop_req = 1'b0;
      chk("stream_last", 32'(Pop_data), 32'h12B);
      chk("stream_empty", 32'(Fifo_empty), 32'h1);
      des_rd_chk("stream_total", 3'd4, 8'd44);
      des_rd_chk("stream_carry", 3'd2, 8'd255);
      des_rd_chk("stream_drop", 3'd3, 8'd0);

      // Clear with entries buffered and a concurrent push.
      push(8'h41, 1'b1);
      push(8'h42, 1'b1);
      push(8'h43, 1'b0);
      Sum_result = 8'h44; Sum_carry = 1'b1; Data_ready = 1'b1;
      Des_req_valid = 1'b1; Des_wr_rd = 1'b1; Des_address = 3'd0; Des_value = 8'h03;
      tick();
      Data_ready = 1'b0; Des_req_valid = 1'b0; Des_wr_rd = 1'b0;
      chk("clr_empty", 32'(Fifo_empty), 32'h1);
      des_rd_chk("clr_lvl", 3'd1, 8'd0);
      des_rd_chk("clr_carry", 3'd2, 8'd0);
      des_rd_chk("clr_drop", 3'd3, 8'd0);
      des_rd_chk("clr_total", 3'd4, 8'd0);
      des_rd_chk("clr_ctrl", 3'd0, 8'h01);

      // Reset mid-burst.
      push(8'h51, 1'b0);
      push(8'h52, 1'b0);
      pop_chk("pre_rst_pop", 9'h051);
      Sum_result = 8'h53; Data_ready = 1'b1; Pop_req = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; Data_ready = 1'b0; Pop_req = 1'b0;
      chk("mid_rst_valid", 32'(Pop_valid), 32'h0);
      chk("mid_rst_data", 32'(Pop_data), 32'h0);
      chk("mid_rst_empty", 32'(Fifo_empty), 32'h1);
      chk("mid_rst_full", 32'(Fifo_full), 32'h0);
      chk("mid_rst_rd", 32'(Des_rd_value), 32'h0);
      des_rd_chk("mid_rst_total", 3'd4, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
